// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared state encoding and default widths for the FIFO stream reader.
package fifo_stream_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int LEN_WIDTH_DEF  = 16;
endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry in-order output buffer; head is presented, tail catches the word behind it.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int W = DATA_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  always_comb begin
    cnt_d  = cnt_q + 2'(push_i) - 2'(pop_i);
    head_d = pop_i ? (cnt_q == 2'd2 ? tail_q : (push_i ? data_i : head_q))
                   : ((cnt_q == 2'd0 && push_i) ? data_i : head_q);
    tail_d = (push_i && cnt_d == 2'd2) ? data_i : tail_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
  assign valid_o = cnt_q != 2'd0;
  assign data_o  = head_q;
  assign count_o = cnt_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a burst of words from a registered-read FIFO onto a valid/ready stream.
// Optional FIFO_STREAM_READER_CNT_EN adds word_cnt, a free-running count of stream transfers.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_cs,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
`ifdef FIFO_STREAM_READER_CNT_EN
  , output logic [31:0]         word_cnt
`endif
);
  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] issue_rem_q, issue_rem_d, out_rem_q, out_rem_d;
  logic                 inflight_q, done_q, done_d, rd, pop, start_ok;
  logic [1:0]           buf_cnt;
  logic [2:0]           level;
  stream_skid_buf #(.W(DATA_WIDTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .data_i  (fifo_data),
    .pop_i   (pop),
    .valid_o (m_valid),
    .data_o  (m_data),
    .count_o (buf_cnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_rem_q <= '0;
      out_rem_q   <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_rem_q <= issue_rem_d;
      out_rem_q   <= out_rem_d;
      inflight_q  <= rd;
      done_q      <= done_d;
    end
  end
  // Occupancy counts words already in flight, minus the one leaving this cycle, so reads never overfill the buffer.
  always_comb begin
    pop      = m_valid && m_ready;
    start_ok = state_q == IDLE && start;
    level    = 3'(buf_cnt) + 3'(inflight_q) - 3'(pop);
    rd       = !rst && state_q == RUN && !fifo_empty && issue_rem_q != '0 && level < 3'd2;
    state_d  = state_q == IDLE ? ((start && burst_len != '0) ? RUN : IDLE)
             : state_q == RUN  ? ((rd && issue_rem_q == LEN_WIDTH'(1)) ? DRAIN : RUN)
             : ((buf_cnt == 2'd0 && !inflight_q) ? IDLE : DRAIN);
    issue_rem_d = start_ok ? burst_len : issue_rem_q - LEN_WIDTH'(rd);
    out_rem_d   = start_ok ? burst_len : out_rem_q - LEN_WIDTH'(pop);
    done_d      = (start_ok && burst_len == '0) || (state_q == DRAIN && state_d == IDLE);
  end
  always_comb begin
    busy       = state_q != IDLE;
    done       = done_q;
    fifo_rd_en = rd;
    fifo_rd_cs = rd;
    m_last     = m_valid && out_rem_q == LEN_WIDTH'(1);
  end
`ifdef FIFO_STREAM_READER_CNT_EN
  logic [31:0] word_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) word_cnt_q <= '0;
    else word_cnt_q <= word_cnt_q + 32'(pop);
  end
  assign word_cnt = word_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed and randomized bursts against a queue-based FIFO/stream reference.
module tb_fifo_stream_reader;
  localparam int DW = 32;
  localparam int LW = 16;
  logic clk = 1'b0;
  logic rst, start, fifo_empty, m_ready;
  logic [LW-1:0] burst_len;
  logic [DW-1:0] fifo_data;
  logic busy, done, fifo_rd_cs, fifo_rd_en, m_valid, m_last;
  logic [DW-1:0] m_data;
`ifdef FIFO_STREAM_READER_CNT_EN
  logic [31:0] word_cnt;
`endif
  fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .fifo_rd_cs (fifo_rd_cs),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready)
`ifdef FIFO_STREAM_READER_CNT_EN
    , .word_cnt (word_cnt)
`endif
  );
  always #5 clk = ~clk;
  int cmp_n = 0, err_n = 0;
  int cyc = 0, rem = 0, done_at = -1, start_cyc = 0, first_valid = -1, last_pop = -1, rmode = 0;
  bit active = 0, last_rd = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask
  // One clock: check mid-cycle, then model the FIFO's registered read and drive the next inputs.
  task automatic tick();
    logic rd, pop;
    @(negedge clk);
    rd = fifo_rd_en;
    pop = m_valid && m_ready;
    last_rd = rd;
    check("rd_cs", fifo_rd_cs, fifo_rd_en);
    if (rd) check("rd_while_empty", fifo_empty, 0);
    if (!active) check("rd_idle", fifo_rd_en, 0);
    check("done", done, cyc == done_at);
    check("busy", busy, active && cyc > start_cyc && (done_at < 0 || cyc < done_at));
    if (m_valid) begin
      if (first_valid < 0) first_valid = cyc;
      check("spurious_valid", exp_q.size() != 0 && rem != 0, 1);
      if (exp_q.size() != 0 && rem != 0) begin
        check("m_data", m_data, exp_q[0]);
        check("m_last", m_last, rem == 1);
      end
    end else check("m_last_idle", m_last, 0);
    if (pop && exp_q.size() != 0 && rem != 0) begin
      void'(exp_q.pop_front());
      rem--;
      last_pop = cyc;
      if (rem == 0) done_at = cyc + 2;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rd && fq.size() != 0) fifo_data = fq.pop_front();
    fifo_empty = fq.size() == 0;
    m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? ~m_ready : 1'($urandom_range(0, 1));
  endtask
  task automatic run_burst(input int len, input int mode, input int preload, input int gap, input int budget);
    int w_left;
    rmode = mode;
    for (int i = 0; i < preload; i++) push_word($urandom);
    fifo_empty = fq.size() == 0;
    start = 1'b1;
    burst_len = LW'(len);
    start_cyc = cyc;
    first_valid = -1;
    rem = len;
    active = len != 0;
    done_at = len == 0 ? cyc + 1 : -1;
    w_left = gap > 0 ? len : 0;
    tick();
    start = 1'b0;
    while (!(done_at >= 0 && cyc > done_at) && cyc - start_cyc < budget) begin
      if (w_left > 0 && (cyc - start_cyc) % gap == 0) begin
        push_word($urandom);
        w_left--;
      end
      start = (mode == 2 && rem > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      burst_len = LW'($urandom);
      tick();
    end
    start = 1'b0;
    active = 0;
    check("burst_complete", done_at >= 0 && cyc > done_at, 1);
    check("words_left", rem, 0);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    burst_len = '0;
    m_ready = 1'b1;
    fifo_empty = 1'b1;
    fifo_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_rd_cs", fifo_rd_cs, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    rst = 1'b0;
    repeat (2) tick();
    // Preloaded 1..8 at full rate: first word three cycles after start, then back to back.
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    run_burst(8, 0, 0, 0, 40);
    check("first_valid", first_valid, start_cyc + 3);
    check("last_pop", last_pop, start_cyc + 10);
    run_burst(4, 1, 4, 0, 60);
    run_burst(3, 0, 0, 10, 80);
    run_burst(0, 0, 2, 0, 10);
    run_burst(2, 2, 0, 0, 40);
    // Abandon a burst with a read in flight.
    push_word($urandom);
    push_word($urandom);
    push_word($urandom);
    push_word($urandom);
    rmode = 0;
    start = 1'b1;
    burst_len = LW'(4);
    start_cyc = cyc;
    active = 1;
    rem = 4;
    done_at = -1;
    tick();
    start = 1'b0;
    tick();
    check("rst_setup_rd", last_rd, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rd_en", fifo_rd_en, 0);
    check("mid_rst_rd_cs", fifo_rd_cs, 0);
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_last", m_last, 0);
    check("mid_rst_data", m_data, 0);
    rst = 1'b0;
    fq.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    active = 0;
    rem = 0;
    done_at = -1;
    repeat (6) tick();
    run_burst(5, 0, 5, 0, 40);
    run_burst(7, 2, 7, 0, 100);
`ifdef FIFO_STREAM_READER_CNT_EN
    check("word_cnt", word_cnt, 12);
`endif
    for (int n = 0; n < 12; n++) begin
      int len;
      len = $urandom_range(1, 12);
      if (n % 2 == 0) run_burst(len, 2, len + $urandom_range(0, 2), 0, 400);
      else run_burst(len, 2, 0, $urandom_range(1, 4), 400);
    end
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
